// File: rtl/mmio_io_responder.sv
// MMIO responder: debounced switch reads, LED and HEX word registers on the CPU data bus.
// Optional MMIO_SW_EDGE_EN adds a read-to-clear rising-edge register for the debounced switches.
module mmio_io_responder #(
  parameter int                DATA_W     = 16,
  parameter int                ADDR_W     = 9,
  parameter int                SW_W       = 8,
  parameter logic [ADDR_W-1:0] SW_ADDR    = 9'h140,
  parameter logic [ADDR_W-1:0] LED_ADDR   = 9'h100,
  parameter logic [ADDR_W-1:0] HEX_ADDR   = 9'h101,
  parameter int                DEB_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              rd_en,
  input  logic [SW_W-1:0]   sw_in,
  output logic [SW_W-1:0]   ledr,
  output logic [DATA_W-1:0] hex_word
);

  // state | meaning
  // IDLE  | no response this cycle; rd_en=0, read_data=0
  // RESP  | response cycle; rd_en=1, read_data holds the value captured at the sampling edge
  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam int PAD_W = DATA_W - SW_W;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] rdata_q, rdata_sel;
  logic              mapped, hit_read, wr_en;

  logic [SW_W-1:0]   sw_meta, sw_sync, sw_stable;
  logic [CNT_W-1:0]  deb_cnt;
  logic              deb_accept;

  // Two-flop synchronizer for the raw switches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw_in;
      sw_sync <= sw_meta;
    end
  end

  assign deb_accept = (sw_sync != sw_stable) && (deb_cnt == DEB_LAST);

  // Any return to sw_stable before acceptance restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_cnt   <= '0;
      sw_stable <= '0;
    end else if (sw_sync == sw_stable) begin
      deb_cnt <= '0;
    end else if (deb_accept) begin
      deb_cnt   <= '0;
      sw_stable <= sw_sync;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

`ifdef MMIO_SW_EDGE_EN
  localparam logic [ADDR_W-1:0] EDGE_ADDR = SW_ADDR + 1'b1;
  logic [SW_W-1:0] sw_edge, sw_rise;
  logic            edge_clr;

  assign sw_rise  = deb_accept ? (sw_sync & ~sw_stable) : '0;
  assign edge_clr = (mem_cmd == CMD_READ) && (mem_addr == EDGE_ADDR);

  // A set on the same edge as a read-clear wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sw_edge <= '0;
    else          sw_edge <= (edge_clr ? '0 : sw_edge) | sw_rise;
  end
`endif

  always_comb begin
    mapped    = 1'b1;
    rdata_sel = '0;
    if (mem_addr == SW_ADDR)       rdata_sel = {{PAD_W{1'b0}}, sw_stable};
    else if (mem_addr == LED_ADDR) rdata_sel = {{PAD_W{1'b0}}, ledr};
    else if (mem_addr == HEX_ADDR) rdata_sel = hex_word;
`ifdef MMIO_SW_EDGE_EN
    else if (mem_addr == EDGE_ADDR) rdata_sel = {{PAD_W{1'b0}}, sw_edge};
`endif
    else mapped = 1'b0;
  end

  assign hit_read = (mem_cmd == CMD_READ) && mapped;
  assign wr_en    = (mem_cmd == CMD_WRITE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ledr     <= '0;
      hex_word <= '0;
    end else if (wr_en) begin
      if (mem_addr == LED_ADDR) ledr     <= write_data[SW_W-1:0];
      if (mem_addr == HEX_ADDR) hex_word <= write_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      rdata_q <= '0;
    end else begin
      state   <= state_nxt;
      rdata_q <= hit_read ? rdata_sel : '0;
    end
  end

  always_comb begin
    state_nxt = IDLE;
    if (hit_read) state_nxt = RESP;
  end

  always_comb begin
    rd_en     = (state == RESP);
    read_data = rd_en ? rdata_q : '0;
  end

endmodule

// File: tb/tb_mmio_io_responder.sv
// Directed bench for mmio_io_responder: debounce latency, bounce rejection, register writes,
// decode, back-to-back reads, async reset mid-response and the optional edge register.
module tb_mmio_io_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        rd_en;
  logic [7:0]  sw_in;
  logic [7:0]  ledr;
  logic [15:0] hex_word;

  int n_checks = 0;
  int n_fail   = 0;

  mmio_io_responder dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mem_cmd    (mem_cmd),
    .mem_addr   (mem_addr),
    .write_data (write_data),
    .read_data  (read_data),
    .rd_en      (rd_en),
    .sw_in      (sw_in),
    .ledr       (ledr),
    .hex_word   (hex_word)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] data);
    mem_cmd    = cmd;
    mem_addr   = addr;
    write_data = data;
  endtask

  initial begin
    reset_n = 1'b0;
    sw_in   = 8'h00;
    bus(2'b00, 9'h000, 16'h0000);
    repeat (3) step();
    check("reset_rd_en", rd_en, 0);
    check("reset_rdata", read_data, 0);
    check("reset_ledr", ledr, 0);
    check("reset_hex", hex_word, 0);
    reset_n = 1'b1;
    step();

    // Bounce: 0F/00 every 2 cycles for 20 cycles never settles long enough.
    for (int i = 0; i < 20; i++) begin
      sw_in = (i % 4 < 2) ? 8'h0F : 8'h00;
      step();
    end
    check("bounce_stable", dut.sw_stable, 8'h00);

    // Hold 0F: accepted on the 6th edge, not the 5th.
    sw_in = 8'h0F;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (i == 5) check("deb_edge5", dut.sw_stable, 8'h00);
      if (i == 6) check("deb_edge6", dut.sw_stable, 8'h0F);
    end

    bus(2'b01, 9'h140, 16'h0000);
    step();
    bus(2'b00, 9'h000, 16'h0000);
    check("sw_rd_en", rd_en, 1);
    check("sw_rdata", read_data, 16'h000F);
    step();
    check("idle_rd_en", rd_en, 0);
    check("idle_rdata", read_data, 16'h0000);

    // Writes and read-after-write.
    bus(2'b10, 9'h100, 16'hAB5A);
    step();
    check("led_write", ledr, 8'h5A);
    check("wr_no_rd_en", rd_en, 0);
    bus(2'b01, 9'h100, 16'h0000);
    step();
    check("led_raw_en", rd_en, 1);
    check("led_raw", read_data, 16'h005A);
    bus(2'b10, 9'h101, 16'h1234);
    step();
    check("hex_write", hex_word, 16'h1234);
    check("hex_wr_rd_en", rd_en, 0);
    bus(2'b10, 9'h140, 16'hFFFF);
    step();
    check("sw_wr_ignored_led", ledr, 8'h5A);
    check("sw_wr_ignored_hex", hex_word, 16'h1234);

    // Decode: unmapped read, then back-to-back mapped reads.
    bus(2'b01, 9'h005, 16'h0000);
    step();
    check("unmap_rd_en", rd_en, 0);
    check("unmap_rdata", read_data, 16'h0000);
    bus(2'b01, 9'h140, 16'h0000);
    step();
    bus(2'b01, 9'h101, 16'h0000);
    check("b2b1_rd_en", rd_en, 1);
    check("b2b1_rdata", read_data, 16'h000F);
    step();
    bus(2'b11, 9'h101, 16'h0000);
    check("b2b2_rd_en", rd_en, 1);
    check("b2b2_rdata", read_data, 16'h1234);
    step();
    check("cmd11_rd_en", rd_en, 0);
    check("cmd11_rdata", read_data, 16'h0000);

    // Async reset in the middle of a response.
    bus(2'b01, 9'h101, 16'h0000);
    step();
    bus(2'b00, 9'h000, 16'h0000);
    check("pre_rst_rd_en", rd_en, 1);
    #1 reset_n = 1'b0;
    #1;
    check("async_rd_en", rd_en, 0);
    check("async_rdata", read_data, 16'h0000);
    check("async_ledr", ledr, 8'h00);
    check("async_hex", hex_word, 16'h0000);
    step();
    reset_n = 1'b1;
    sw_in   = 8'h00;
    step();

    sw_in = 8'h01;
    repeat (8) step();
    check("sw01_stable", dut.sw_stable, 8'h01);
`ifdef MMIO_SW_EDGE_EN
    bus(2'b01, 9'h141, 16'h0000);
    step();
    check("edge_rd1_en", rd_en, 1);
    check("edge_rd1", read_data, 16'h0001);
    step();
    bus(2'b00, 9'h000, 16'h0000);
    check("edge_rd2_en", rd_en, 1);
    check("edge_rd2", read_data, 16'h0000);
    step();
`else
    bus(2'b01, 9'h141, 16'h0000);
    step();
    bus(2'b00, 9'h000, 16'h0000);
    check("edge_unmap_en", rd_en, 0);
    check("edge_unmap_rdata", read_data, 16'h0000);
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
